boot_loader: RTL and testbench

- Program loader upstream of the pipeline CPU top.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit little-endian words.
- Writes each word into the SPM through the CPU top's test_spm_* port.
- Asserts cpu_en once the image is complete. Until then cpu_en=0, so the CPU top routes the SPM data port to this block.

---
 rtl/boot_loader_pkg.sv | 20 ++
 rtl/boot_loader_if.sv | 30 +++
 rtl/boot_loader_byte_assembler.sv | 30 +++
 rtl/boot_loader.sv | 110 +++++++++++
 tb/tb_boot_loader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state encoding and SPM bus constants for the boot loader
package boot_loader_pkg;

  localparam int BL_ADDR_W     = 30;
  localparam int BL_BYTE_CNT_W = 2;

  localparam logic SPM_READ  = 1'b1;
  localparam logic SPM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    BL_IDLE,
    BL_HDR,
    BL_DATA,
    BL_WRITE,
    BL_CHK,
    BL_RUN,
    BL_ERROR
  } bl_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - byte stream, SPM test port and status signals of the boot loader
interface boot_loader_if;
  import boot_loader_pkg::*;

  logic                 start;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic [BL_ADDR_W-1:0] test_spm_addr;
  logic                 test_spm_as_;
  logic                 test_spm_rw;
  logic [31:0]          test_spm_wr_data;
  logic [31:0]          test_spm_rd_data;
  logic                 cpu_en;
  logic                 load_done;
  logic                 load_err;

  modport master (
    output start, rx_valid, rx_data, test_spm_rd_data,
    input  rx_ready, test_spm_addr, test_spm_as_, test_spm_rw, test_spm_wr_data,
    input  cpu_en, load_done, load_err
  );

  modport slave (
    input  start, rx_valid, rx_data, test_spm_rd_data,
    output rx_ready, test_spm_addr, test_spm_as_, test_spm_rw, test_spm_wr_data,
    output cpu_en, load_done, load_err
  );

endinterface

// File: rtl/boot_loader_byte_assembler.sv
// rtl/boot_loader_byte_assembler.sv - 4-byte little-endian word assembler with word_valid pulse
module boot_loader_byte_assembler
  import boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0]              r_buf;
  logic [BL_BYTE_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_byte_en) begin
      r_buf <= {i_byte, r_buf[23:8]};
      r_cnt <= r_cnt + BL_BYTE_CNT_W'(1);
    end
  end

  // Word is presented in the cycle its 4th byte is accepted; the caller registers it.
  assign o_word       = {i_byte, r_buf};
  assign o_word_valid = i_byte_en && (r_cnt == '1);

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream program loader into SPM; BOOT_LOADER_CHECKSUM_EN adds an XOR checksum trailer
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [BL_ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                   MAX_WORDS = 4096
) (
  input  logic          i_clk,
  input  logic          i_rst,
  boot_loader_if.slave  io_bus
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bl_state_e BL_LAST = BL_CHK;
`else
  localparam bl_state_e BL_LAST = BL_RUN;
`endif

  bl_state_e            r_state, w_next;
  logic [31:0]          r_n, r_idx;
  logic                 r_rx_ready, r_as_n, r_rw, r_cpu_en, r_done, r_err;
  logic [BL_ADDR_W-1:0] r_addr;
  logic [31:0]          r_wr_data;
  logic [31:0]          w_word;
  logic                 w_word_valid, w_accept, w_unused;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0]          r_xor;
`endif

  assign w_accept = io_bus.rx_valid && r_rx_ready;
  assign w_unused = &{1'b0, io_bus.test_spm_rd_data};

  boot_loader_byte_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte_en    (w_accept),
    .i_byte       (io_bus.rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      BL_IDLE:  if (io_bus.start) w_next = BL_HDR;
      BL_HDR:   if (w_word_valid) begin
                  if (w_word == 32'd0)                   w_next = BL_LAST;
                  else if (w_word > 32'(MAX_WORDS))      w_next = BL_ERROR;
                  else                                   w_next = BL_DATA;
                end
      BL_DATA:  if (w_word_valid) w_next = BL_WRITE;
      BL_WRITE: w_next = (r_idx == r_n - 32'd1) ? BL_LAST : BL_DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
      BL_CHK:   if (w_word_valid) w_next = (w_word == r_xor) ? BL_RUN : BL_ERROR;
`endif
      BL_RUN:   w_next = BL_RUN;
      BL_ERROR: w_next = BL_ERROR;
      default:  w_next = BL_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= BL_IDLE;
      r_n        <= '0;
      r_idx      <= '0;
      r_rx_ready <= 1'b0;
      r_as_n     <= 1'b1;
      r_rw       <= SPM_READ;
      r_addr     <= BASE_ADDR;
      r_wr_data  <= '0;
      r_cpu_en   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_rx_ready <= (w_next == BL_HDR) || (w_next == BL_DATA) || (w_next == BL_CHK);
      r_as_n     <= (w_next != BL_WRITE);
      r_rw       <= (w_next == BL_WRITE) ? SPM_WRITE : SPM_READ;
      r_cpu_en   <= (w_next == BL_RUN);
      r_done     <= (w_next == BL_RUN);
      r_err      <= (w_next == BL_ERROR);
      if (r_state == BL_HDR && w_word_valid)
        r_n <= w_word;
      if (r_state == BL_DATA && w_word_valid) begin
        r_addr    <= BASE_ADDR + r_idx[BL_ADDR_W-1:0];
        r_wr_data <= w_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
        r_xor     <= r_xor ^ w_word;
`endif
      end
      if (r_state == BL_WRITE)
        r_idx <= r_idx + 32'd1;
    end
  end

  assign io_bus.rx_ready         = r_rx_ready;
  assign io_bus.test_spm_as_     = r_as_n;
  assign io_bus.test_spm_rw      = r_rw;
  assign io_bus.test_spm_addr    = r_addr;
  assign io_bus.test_spm_wr_data = r_wr_data;
  assign io_bus.cpu_en           = r_cpu_en;
  assign io_bus.load_done        = r_done;
  assign io_bus.load_err         = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader with a write-log image model
module tb_boot_loader;
    import boot_loader_pkg::*;

    logic clk, rst;
    boot_loader_if bus();

    boot_loader dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int checks, errors, tmo_cnt, cyc;
    int dbl_cnt, rw_bad, en_rise;
    bit prev_low, prev_en;
    logic [29:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [31:0] img_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // SPM bus observer: logs every strobed write and protocol violations
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.test_spm_as_ === 1'b0) begin
                wa_q.push_back(bus.test_spm_addr);
                wd_q.push_back(bus.test_spm_wr_data);
                wc_q.push_back(cyc);
                if (prev_low) dbl_cnt++;
                if (bus.test_spm_rw !== SPM_WRITE) rw_bad++;
            end else if (bus.test_spm_rw !== SPM_READ) begin
                rw_bad++;
            end
            prev_low = (bus.test_spm_as_ === 1'b0);
            if (bus.cpu_en === 1'b1 && !prev_en) en_rise = cyc;
            prev_en = (bus.cpu_en === 1'b1);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        dbl_cnt = 0; rw_bad = 0; en_rise = -1; prev_low = 0; prev_en = 0; tmo_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.start = 1'b0; bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.rx_ready !== 1'b1) tmo_cnt++;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = $urandom_range(0, 255);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic load_image(input int max_gap);
        logic [31:0] x = 32'd0;
        pulse_start();
        send_word(32'(img_q.size()), max_gap);
        foreach (img_q[i]) begin
            send_word(img_q[i], max_gap);
            x = x ^ img_q[i];
            if (i == 0) pulse_start();
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_word(x, max_gap);
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.test_spm_rd_data = 32'h0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", bus.rx_ready); end
            checks++;
            if (bus.test_spm_as_ !== 1'b1) begin errors++; $display("FAIL reset_as got %b want 1", bus.test_spm_as_); end
            checks++;
            if (bus.test_spm_rw !== SPM_READ) begin errors++; $display("FAIL reset_rw got %b want %b", bus.test_spm_rw, SPM_READ); end
            checks++;
            if (bus.test_spm_addr !== 30'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.test_spm_addr); end
            checks++;
            if (bus.test_spm_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0", bus.test_spm_wr_data); end
            checks++;
            if ({bus.cpu_en, bus.load_done, bus.load_err} !== 3'b000) begin
                errors++; $display("FAIL reset_status got %b want 000", {bus.cpu_en, bus.load_done, bus.load_err});
            end
            checks++;
            rst = 1'b0;
            repeat (3) @(negedge clk);
        end
        clear_mon();
    endtask

    task automatic test_basic();
        do_reset();
        img_q = '{32'h00000013, 32'h00100093};
        load_image(0);
        if (wa_q.size() !== 2) begin errors++; $display("FAIL basic_nwrites got %0d want 2", wa_q.size()); end
        checks++;
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            if (wa_q[i] !== 30'(i)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", i, wa_q[i], i); end
            checks++;
            if (wd_q[i] !== img_q[i]) begin errors++; $display("FAIL basic_data%0d got %h want %h", i, wd_q[i], img_q[i]); end
            checks++;
        end
        if (dbl_cnt !== 0 || rw_bad !== 0) begin errors++; $display("FAIL basic_strobe got dbl=%0d rw_bad=%0d want 0 0", dbl_cnt, rw_bad); end
        checks++;
`ifndef BOOT_LOADER_CHECKSUM_EN
        if (wc_q.size() == 2) begin
            if (en_rise !== wc_q[1] + 1) begin errors++; $display("FAIL basic_en_timing got %0d want %0d", en_rise, wc_q[1] + 1); end
            checks++;
        end
`endif
        if ({bus.cpu_en, bus.load_done, bus.load_err, bus.rx_ready} !== 4'b1100) begin
            errors++; $display("FAIL basic_run got %b want 1100", {bus.cpu_en, bus.load_done, bus.load_err, bus.rx_ready});
        end
        checks++;
        if (tmo_cnt !== 0) begin errors++; $display("FAIL basic_accept got %0d timeouts want 0", tmo_cnt); end
        checks++;
    endtask

    task automatic test_zero();
        do_reset();
        pulse_start();
        send_word(32'h0, 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        if ({bus.rx_ready, bus.cpu_en} !== 2'b10) begin errors++; $display("FAIL zero_chk got %b want 10", {bus.rx_ready, bus.cpu_en}); end
        checks++;
        send_word(32'h0, 1);
        if ({bus.cpu_en, bus.load_done} !== 2'b11) begin errors++; $display("FAIL zero_chk_run got %b want 11", {bus.cpu_en, bus.load_done}); end
        checks++;
        do_reset();
        pulse_start();
        send_word(32'h0, 1);
        send_word(32'h1, 1);
        if ({bus.load_err, bus.cpu_en} !== 2'b10) begin errors++; $display("FAIL zero_chk_err got %b want 10", {bus.load_err, bus.cpu_en}); end
        checks++;
`else
        if ({bus.cpu_en, bus.load_done, bus.rx_ready} !== 3'b110) begin
            errors++; $display("FAIL zero_run got %b want 110", {bus.cpu_en, bus.load_done, bus.rx_ready});
        end
        checks++;
`endif
        repeat (3) @(negedge clk);
        if (wa_q.size() !== 0) begin errors++; $display("FAIL zero_nwrites got %0d want 0", wa_q.size()); end
        checks++;
    endtask

    task automatic test_too_big();
        do_reset();
        pulse_start();
        send_word(32'd4097, 1);
        repeat (5) @(negedge clk);
        if ({bus.load_err, bus.cpu_en, bus.rx_ready, bus.load_done} !== 4'b1000) begin
            errors++; $display("FAIL big_err got %b want 1000", {bus.load_err, bus.cpu_en, bus.rx_ready, bus.load_done});
        end
        checks++;
        if (wa_q.size() !== 0) begin errors++; $display("FAIL big_nwrites got %0d want 0", wa_q.size()); end
        checks++;
        do_reset();
        pulse_start();
        send_word(32'd4096, 1);
        if ({bus.rx_ready, bus.load_err} !== 2'b10) begin errors++; $display("FAIL max_accept got %b want 10", {bus.rx_ready, bus.load_err}); end
        checks++;
        send_word(32'hDEADBEEF, 1);
        @(negedge clk);
        if (wa_q.size() !== 1 || wd_q[0] !== 32'hDEADBEEF || bus.cpu_en !== 1'b0) begin
            errors++; $display("FAIL max_first_write got n=%0d d=%h en=%b want 1 deadbeef 0", wa_q.size(), wd_q[0], bus.cpu_en);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 16);
            img_q.delete();
            for (int i = 0; i < n; i++) img_q.push_back($urandom());
            load_image(3);
            if (wa_q.size() !== n) begin errors++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, wa_q.size(), n); end
            checks++;
            for (int i = 0; i < n && i < wa_q.size(); i++) begin
                if (wa_q[i] !== 30'(i) || wd_q[i] !== img_q[i]) begin
                    errors++; $display("FAIL rand%0d_word%0d got %h@%h want %h@%h", it, i, wd_q[i], wa_q[i], img_q[i], i);
                end
                checks++;
            end
            if (dbl_cnt !== 0 || rw_bad !== 0 || tmo_cnt !== 0) begin
                errors++; $display("FAIL rand%0d_proto got dbl=%0d rw=%0d tmo=%0d want 0 0 0", it, dbl_cnt, rw_bad, tmo_cnt);
            end
            checks++;
            if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL rand%0d_cpu_en got %b want 1", it, bus.cpu_en); end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w1;
        do_reset();
        w1 = $urandom();
        pulse_start();
        send_word(32'd3, 0);
        send_word($urandom(), 0);
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        #2 rst = 1'b1;
        #1;
        if ({bus.rx_ready, bus.test_spm_as_, bus.test_spm_rw, bus.cpu_en, bus.load_done, bus.load_err} !== {3'b01, SPM_READ, 3'b000}
            || bus.test_spm_addr !== 30'h0 || bus.test_spm_wr_data !== 32'h0) begin
            errors++; $display("FAIL midreset_outputs got rdy=%b as=%b rw=%b addr=%h wd=%h want 0 1 %b 0 0",
                bus.rx_ready, bus.test_spm_as_, bus.test_spm_rw, bus.test_spm_addr, bus.test_spm_wr_data, SPM_READ);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        img_q = '{$urandom(), $urandom()};
        load_image(2);
        if (wa_q.size() !== 2 || wa_q[0] !== 30'h0 || wd_q[0] !== img_q[0] || wd_q[1] !== img_q[1]) begin
            errors++; $display("FAIL midreset_reload got n=%0d a0=%h d0=%h d1=%h want 2 0 %h %h",
                wa_q.size(), wa_q[0], wd_q[0], wd_q[1], img_q[0], img_q[1]);
        end
        checks++;
        #3 rst = 1'b1;
        #1;
        if ({bus.cpu_en, bus.load_done} !== 2'b00) begin errors++; $display("FAIL async_drop got %b want 00", {bus.cpu_en, bus.load_done}); end
        checks++;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            pulse_start();
            send_word(32'd2, 1);
            send_word(32'hA5A5A5A5, 1);
            send_word(32'h0F0F0F0F, 1);
            send_word(32'hAAAAAAAA + 32'(k), 1);
            @(negedge clk);
            if ({bus.cpu_en, bus.load_err} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL chk%0d_result got %b want %b", k, {bus.cpu_en, bus.load_err}, (k == 0) ? 2'b10 : 2'b01);
            end
            checks++;
            if (wa_q.size() !== 2 || wd_q[1] !== 32'h0F0F0F0F) begin
                errors++; $display("FAIL chk%0d_writes got n=%0d d1=%h want 2 0f0f0f0f", k, wa_q.size(), wd_q[1]);
            end
            checks++;
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0; cyc = 0;
        clear_mon();
        test_reset();
        test_basic();
        test_zero();
        test_too_big();
        test_random();
        test_reset_mid();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
